// File: rtl/pe_gs_inv.sv
// Gentleman-Sande inverse-NTT butterfly for q = 3329: upper = u+v, lower = (u-v)*w,
// both optionally halved mod q. Fully pipelined, one butterfly per clock.

module modular_mul #(
  parameter int DW  = 12,
  parameter int Q   = 3329,
  parameter int LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LAT-1:0] i_en,
  input  logic [DW-1:0]  i_a,
  input  logic [DW-1:0]  i_b,
  output logic [DW-1:0]  o_p
);
  localparam int PW = 2 * DW;
  localparam int RW = DW + 2;
  localparam int XW = PW + DW + 1;
  // Barrett constant floor(2^PW / Q); the quotient estimate is short by at most one.
  localparam logic [DW:0]   BM   = (DW+1)'((64'd1 << PW) / Q);
  localparam logic [RW-1:0] Q_R  = RW'(Q);
  localparam logic [RW-1:0] Q2_R = RW'(2 * Q);

  logic [PW-1:0] r_p;
  logic [RW-1:0] r_p1;
  logic [DW:0]   r_qh;
  logic [RW-1:0] r_r;
  logic [DW-1:0] r_o [LAT-3];

  logic [XW-1:0] w_pm;
  logic [RW-1:0] w_qq;
  logic [DW-1:0] w_red;

  assign w_pm  = {{(DW+1){1'b0}}, r_p} * {{PW{1'b0}}, BM};
  assign w_qq  = {1'b0, r_qh} * Q_R;
  assign w_red = (r_r >= Q2_R) ? DW'(r_r - Q2_R) :
                 (r_r >= Q_R)  ? DW'(r_r - Q_R)  : DW'(r_r);
  assign o_p   = r_o[LAT-4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= '0;
      r_p1 <= '0;
      r_qh <= '0;
      r_r  <= '0;
      for (int k = 0; k <= LAT - 4; k++) r_o[k] <= '0;
    end else begin
      if (i_en[0]) r_p <= {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
      if (i_en[1]) begin
        r_qh <= (DW+1)'(w_pm >> PW);
        r_p1 <= r_p[RW-1:0];
      end
      // Remainder is below 2q, so modulo-2^RW arithmetic is exact here.
      if (i_en[2]) r_r <= r_p1 - w_qq;
      if (i_en[3]) r_o[0] <= w_red;
      for (int k = 1; k <= LAT - 4; k++)
        if (i_en[3+k]) r_o[k] <= r_o[k-1];
    end
  end
endmodule

module pe_gs_inv #(
  parameter int data_width = 12,
  parameter int Q          = 3329,
  parameter int W_CONST    = 169,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  sel,
  input  logic                  half_en,
  input  logic [data_width-1:0] u,
  input  logic [data_width-1:0] v,
  input  logic [data_width-1:0] w,
  output logic                  valid_out,
  output logic [data_width-1:0] bf_upper,
  output logic [data_width-1:0] bf_lower,
  output logic                  busy
);
  localparam int DW = data_width;
  localparam logic [DW-1:0] Q_L = DW'(Q);
  localparam logic [DW-1:0] W_L = DW'(W_CONST);

  function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
    logic [DW:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, Q_L} : '0);
    return DW'(t >> 1);
  endfunction

  // S1
  logic [DW-1:0] r_u1, r_v1, r_w1;
  logic          r_h1, r_vld1;
  // S2
  logic [DW-1:0] r_sum2, r_diff2, r_w2;
  logic          r_h2, r_vld2;
  // S3 side-band delay line aligned with the multiplier
  logic [DW-1:0]      r_sd [MUL_LAT];
  logic [MUL_LAT-1:0] r_hd, r_vd;
  // S4
  logic [DW-1:0] r_up, r_lo;
  logic          r_vout, r_busy;

  logic [DW:0]        w_sum_raw, w_diff_raw;
  logic [DW-1:0]      w_sum, w_diff, w_prod, w_up, w_lo;
  logic [MUL_LAT-1:0] w_en;

  assign w_sum_raw  = {1'b0, r_u1} + {1'b0, r_v1};
  assign w_sum      = (w_sum_raw >= {1'b0, Q_L}) ? DW'(w_sum_raw - {1'b0, Q_L}) : DW'(w_sum_raw);
  assign w_diff_raw = {1'b0, r_u1} - {1'b0, r_v1};
  assign w_diff     = (r_u1 < r_v1) ? DW'(w_diff_raw + {1'b0, Q_L}) : DW'(w_diff_raw);

  // Each multiplier/delay stage loads only when the beat entering it is valid.
  assign w_en = {r_vd[MUL_LAT-2:0], r_vld2};

  modular_mul #(.DW(DW), .Q(Q), .LAT(MUL_LAT)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_en),
    .i_a  (r_diff2),
    .i_b  (r_w2),
    .o_p  (w_prod)
  );

  assign w_up = r_hd[MUL_LAT-1] ? halve(r_sd[MUL_LAT-1]) : r_sd[MUL_LAT-1];
  assign w_lo = r_hd[MUL_LAT-1] ? halve(w_prod)          : w_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_u1 <= '0; r_v1 <= '0; r_w1 <= '0; r_h1 <= 1'b0; r_vld1 <= 1'b0;
      r_sum2 <= '0; r_diff2 <= '0; r_w2 <= '0; r_h2 <= 1'b0; r_vld2 <= 1'b0;
      for (int k = 0; k < MUL_LAT; k++) r_sd[k] <= '0;
      r_hd <= '0; r_vd <= '0;
      r_up <= '0; r_lo <= '0; r_vout <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_vld1 <= valid_in;
      if (valid_in) begin
        r_u1 <= u;
        r_v1 <= v;
        r_w1 <= sel ? w : W_L;
        r_h1 <= half_en;
      end
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_sum2  <= w_sum;
        r_diff2 <= w_diff;
        r_w2    <= r_w1;
        r_h2    <= r_h1;
      end
      r_vd <= w_en;
      for (int k = 0; k < MUL_LAT; k++) begin
        if (w_en[k]) begin
          r_sd[k] <= (k == 0) ? r_sum2 : r_sd[(k == 0) ? 0 : k-1];
          r_hd[k] <= (k == 0) ? r_h2   : r_hd[(k == 0) ? 0 : k-1];
        end
      end
      r_vout <= r_vd[MUL_LAT-1];
      if (r_vd[MUL_LAT-1]) begin
        r_up <= w_up;
        r_lo <= w_lo;
      end
      r_busy <= valid_in | r_vld1 | r_vld2 | (|r_vd);
    end
  end

  assign valid_out = r_vout;
  assign bf_upper  = r_up;
  assign bf_lower  = r_lo;
  assign busy      = r_busy;
endmodule

// File: tb/tb_pe_gs_inv.sv
// Randomised and directed checks of pe_gs_inv against a modular-arithmetic model
// with an expected-output queue tracking cycle-exact arrival.

module tb_pe_gs_inv;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0, sel = 1'b0, half_en = 1'b0;
  logic [11:0] u = '0, v = '0, w = '0;
  logic        valid_out, busy;
  logic [11:0] bf_upper, bf_lower;

  pe_gs_inv dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sel(sel), .half_en(half_en),
    .u(u), .v(v), .w(w), .valid_out(valid_out), .bf_upper(bf_upper),
    .bf_lower(bf_lower), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int samp; int ecyc; int up; int lo; } exp_t;
  exp_t eq[$];

  int n_checks = 0, n_fail = 0;
  bit skip = 1'b1;
  int last_up = 0, last_lo = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_bf(input int a, input int b, input int tw, input bit s,
                                 input bit h, output int up, output int lo);
    int t;
    t  = s ? tw : 169;
    up = (a + b) % Q;
    lo = (((a - b + Q) % Q) * t) % Q;
    if (h) begin
      up = (up * 1665) % Q;   // 1665 = 2^-1 mod q
      lo = (lo * 1665) % Q;
    end
  endfunction

  always @(negedge clk) begin : monitor
    bit ev, eb;
    if (!skip) begin
      ev = (eq.size() > 0) && (eq[0].ecyc == cyc);
      eb = (eq.size() > 0) && (eq[0].samp <= cyc);
      check_val("valid_out", valid_out, ev);
      check_val("busy", busy, eb);
      if (valid_out) begin
        if (ev) begin
          check_val("bf_upper", bf_upper, eq[0].up);
          check_val("bf_lower", bf_lower, eq[0].lo);
        end
        last_up = bf_upper;
        last_lo = bf_lower;
      end else begin
        check_val("hold_upper", bf_upper, last_up);
        check_val("hold_lower", bf_lower, last_lo);
      end
      if (ev) void'(eq.pop_front());
    end
  end

  task automatic send(input int a, input int b, input int tw, input bit s, input bit h,
                      input int eu, input int el);
    exp_t e;
    @(posedge clk); #1;
    valid_in = 1'b1; u = 12'(a); v = 12'(b); w = 12'(tw); sel = s; half_en = h;
    e.samp = cyc + 1; e.ecyc = cyc + 7; e.up = eu; e.lo = el;
    eq.push_back(e);
  endtask

  task automatic send_rand();
    int a, b, tw, eu, el;
    bit s, h;
    a = $urandom_range(Q-1); b = $urandom_range(Q-1); tw = $urandom_range(Q-1);
    s = 1'($urandom); h = 1'($urandom);
    ref_bf(a, b, tw, s, h, eu, el);
    send(a, b, tw, s, h, eu, el);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      u = 12'($urandom_range(Q-1)); v = 12'($urandom_range(Q-1)); w = 12'($urandom_range(Q-1));
      sel = 1'($urandom); half_en = 1'($urandom);
    end
  endtask

  initial begin
    int fu, fl, a, b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_valid_out", valid_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_upper", bf_upper, 0);
    check_val("rst_lower", bf_lower, 0);
    skip = 1'b0;

    // Directed corner beats with hand-derived results.
    send(5, 3, 1, 1, 0, 8, 2);
    idle(8);
    send(5, 3, 1, 1, 1, 4, 1);
    send(3, 5, 1, 1, 1, 4, 3328);
    send(3328, 2, 1, 1, 0, 1, 3326);
    send(0, 1, $urandom_range(Q-1), 0, 0, 1, 3160);
    send(0, 1, $urandom_range(Q-1), 0, 1, 1665, 1580);
    idle(10);

    // Streaming with a 3-cycle gap.
    for (int i = 0; i < 64; i++) send_rand();
    idle(3);
    for (int i = 0; i < 16; i++) send_rand();
    idle(10);

    // Reset mid-stream drops everything in flight.
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk); #1;
    valid_in = 1'b0; rst = 1'b1; skip = 1'b1;
    eq.delete(); last_up = 0; last_lo = 0;
    @(posedge clk); #1 skip = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("postrst_valid_out", valid_out, 0);
      check_val("postrst_upper", bf_upper, 0);
      check_val("postrst_lower", bf_lower, 0);
      check_val("postrst_busy", busy, 0);
    end

    // Forward-PE outputs fed back must reproduce the original pair.
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom_range(Q-1); b = $urandom_range(Q-1);
      fu = (a + (b * 2285) % Q) % Q;
      fl = (a + Q - (b * 2285) % Q) % Q;
      send(fu, fl, $urandom_range(Q-1), 0, 1, a, b);
    end
    idle(20);
    check_val("drain", eq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
